// File: rtl/fsk4_symbol_framer.sv
// Byte-to-symbol framer feeding the 4-FSK modulator: one start pulse per frame,
// MSB-first 2-bit symbols held for a fixed sample count, fill symbols on underrun.
`timescale 1ns/1ps
module fsk4_symbol_framer #(
    parameter int SAMPLES_PER_SYMBOL = 64,
    parameter int GUARD_CYCLES       = 12,
    parameter int GAP_CYCLES         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic [1:0] sym_out,
    output logic       start,
    output logic       sym_strobe,
    output logic       underrun,
    output logic       frame_done,
    output logic       busy
);
    localparam int MAX_A = (SAMPLES_PER_SYMBOL > GUARD_CYCLES) ? SAMPLES_PER_SYMBOL : GUARD_CYCLES;
    localparam int MAX_C = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] SPS_LAST   = CW'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SYNC, SEND, GAP} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_cur;
    logic          r_cur_last;
    logic [7:0]    r_buf;
    logic          r_buf_last;
    logic          r_buf_full;
    logic [1:0]    r_idx;
    logic          r_fill;
    logic          w_xfer;

    function automatic logic [1:0] sym_sel(input logic [7:0] b, input logic [1:0] idx);
        case (idx)
            2'd0:    sym_sel = b[7:6];
            2'd1:    sym_sel = b[5:4];
            2'd2:    sym_sel = b[3:2];
            default: sym_sel = b[1:0];
        endcase
    endfunction

    // Ready is combinational so it drops the moment reset rises.
    always_comb begin
        byte_ready = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE:       byte_ready = 1'b1;
                SYNC, SEND: byte_ready = !r_buf_full && !r_cur_last;
                default:    byte_ready = 1'b0;
            endcase
        end
    end

    assign w_xfer = byte_valid && byte_ready;
    assign busy   = (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cur      <= '0;
            r_cur_last <= 1'b0;
            r_buf      <= '0;
            r_buf_last <= 1'b0;
            r_buf_full <= 1'b0;
            r_idx      <= '0;
            r_fill     <= 1'b0;
            sym_out    <= '0;
            start      <= 1'b0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            start      <= 1'b0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;

            // Buffer writes only happen while it is empty, so they never collide with a drain.
            if (w_xfer && r_state != IDLE) begin
                r_buf      <= byte_data;
                r_buf_last <= byte_last;
                r_buf_full <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_xfer) begin
                        r_cur      <= byte_data;
                        r_cur_last <= byte_last;
                        r_idx      <= '0;
                        r_fill     <= 1'b0;
                        start      <= 1'b1;
                        sym_strobe <= 1'b1;
                        sym_out    <= byte_data[7:6];
                        r_state    <= SYNC;
                    end
                end
                SYNC: begin
                    if (r_cnt == GUARD_LAST) begin
                        r_cnt   <= '0;
                        r_state <= SEND;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (r_cnt != SPS_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                        if (!r_fill && r_idx != 2'd3) begin
                            r_idx      <= r_idx + 2'd1;
                            sym_out    <= sym_sel(r_cur, r_idx + 2'd1);
                            sym_strobe <= 1'b1;
                        end else if (!r_fill && r_cur_last) begin
                            frame_done <= 1'b1;
                            sym_out    <= '0;
                            r_state    <= GAP;
                        end else if (r_buf_full) begin
                            r_cur      <= r_buf;
                            r_cur_last <= r_buf_last;
                            r_buf_full <= 1'b0;
                            r_idx      <= '0;
                            r_fill     <= 1'b0;
                            sym_out    <= r_buf[7:6];
                            sym_strobe <= 1'b1;
                        end else begin
                            r_fill     <= 1'b1;
                            sym_out    <= '0;
                            underrun   <= 1'b1;
                            sym_strobe <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt      <= '0;
                        r_cur_last <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
